// File: rtl/if_instr_queue_pkg.sv
// Shared definitions for the fetch-to-decode instruction queue.
//   IFQ_NOP            : instruction word presented to decode when the queue is empty
//   IFQ_DEPTH_DEFAULT  : default number of queue entries
//   ifq_entry_t        : one stored entry, laid out as {InstrAddr[31:0], Instr[31:0]}
package if_instr_queue_pkg;

  localparam logic [31:0] IFQ_NOP           = 32'h0000_0000;
  localparam int          IFQ_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [31:0] instr_addr;
    logic [31:0] instr;
  } ifq_entry_t;

endpackage

// File: rtl/if_instr_queue_ram.sv
// Entry storage for the instruction queue: DEPTH x 64-bit register array.
//   clk     : rising-edge clock
//   we_i    : write enable
//   waddr_i : write index
//   wdata_i : entry to write
//   raddr_i : read index (asynchronous read)
//   rdata_o : entry at raddr_i
module if_instr_queue_ram
  import if_instr_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  ifq_entry_t    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output ifq_entry_t    rdata_o
);

  ifq_entry_t mem_q [DEPTH];

  // NOTE: storage is deliberately not reset; occupancy is tracked by the
  // count register, so stale contents are never presented as valid.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_instr_queue.sv
// Instruction queue between fetch and decode.
//   clk, RESET                       : clock, synchronous active-high reset
//   F_Valid, F_Instr, F_InstrAddr    : fetched instruction presented this cycle
//   FLUSH                            : drop all entries and this cycle's fetch
//   STALL_EN_N                       : 1 = fetch may advance, 0 = hold PC (queue full)
//   D_Valid, D_Instr, D_InstrAddr    : head entry toward decode (nop/0 when empty)
//   D_Ready                          : decode consumes the head entry this cycle
//   Count                            : current occupancy 0..DEPTH
// All outputs are derived from registered state only.
module if_instr_queue
  import if_instr_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     RESET,
  input  logic                     F_Valid,
  input  logic [31:0]              F_Instr,
  input  logic [31:0]              F_InstrAddr,
  input  logic                     FLUSH,
  output logic                     STALL_EN_N,
  output logic                     D_Valid,
  output logic [31:0]              D_Instr,
  output logic [31:0]              D_InstrAddr,
  input  logic                     D_Ready,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full, empty, push, pop;
  ifq_entry_t    head;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  // Push is gated by the registered full flag, so a pop from full cannot make
  // room for a same-cycle push: fetch already saw STALL_EN_N=0 and retries.
  assign push = F_Valid & ~full  & ~FLUSH;
  assign pop  = D_Ready & ~empty & ~FLUSH;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (FLUSH) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      // Pointers wrap for free through their power-of-two width.
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (pop && !push) cnt_d = cnt_q - CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next-state value from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (RESET) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  if_instr_queue_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i ('{instr_addr: F_InstrAddr, instr: F_Instr}),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  assign STALL_EN_N  = ~full;
  assign D_Valid     = ~empty;
  assign D_Instr     = empty ? IFQ_NOP : head.instr;
  assign D_InstrAddr = empty ? 32'h0   : head.instr_addr;
  assign Count       = cnt_q;

endmodule
